temp_sample_filter: RTL and testbench
=====================================

# temp_sample_filter

Conditions raw 8-bit temperature-sensor samples into the 5-bit level that drives the downstream hysteresis mode FSM's `inp` input. It runs a 4-sample moving average with spike rejection, uses a valid/ready handshake on the sensor side, and emits a held level with strobes. A warm-up phase suppresses output until the averaging window is full.

## Interface
- `DATA_W`, 8: raw sample width
- `OUT_W`, 5: output level width; must be ≤ `DATA_W`
- `DEPTH`, 4: averaging window length; power of 2, ≥2
- `SPIKE_TH`, 64: outlier threshold on |raw − current average|
- `MAX_REJ`, 2: consecutive outliers dropped before the next one is forced in
- `clk` in 1: single clock, all state on posedge
- `rst` in 1: reset, asynchronous, active-high
- `raw` in `DATA_W`: sensor sample
- `raw_valid` in 1: `raw` is valid
- `raw_ready` out 1: block can accept a sample this cycle
- `level` out `OUT_W`: filtered level, held between updates
- `level_valid` out 1: one-cycle pulse when `level` is updated
- `level_changed` out 1: one-cycle pulse with `level_valid` when the new `level` differs from the previous one

## Operation
- Handshake: a sample is accepted on a posedge where `raw_valid && raw_ready`. `raw` is ignored otherwise.
- States:
  - FILL: `count` < `DEPTH`. Every accepted sample enters the window with no spike check. Entering the `DEPTH`-th sample moves to RUN and produces the first output.
  - RUN: spike check applies.
- Each accepted sample is followed by one compute cycle (`busy`=1, `raw_ready`=0).
- Window: shift register of `DEPTH` samples plus a running sum of width `DATA_W`+log2(`DEPTH`), i.e. 10 bits.
  - On entry: sum ← sum + raw − oldest.
  - Oldest reads 0 during FILL. The sum can never overflow.
- Average: avg = sum >> log2(`DEPTH`), `DATA_W` bits, registered.
- Level: avg >> (`DATA_W` − `OUT_W`), i.e. avg[7:3]. Truncation only, no rounding.
- Spike check in RUN:
  - diff = raw − avg, computed signed with `DATA_W`+1 bits.
  - If |diff| > `SPIKE_TH` (strictly greater) the sample is an outlier.
  - An outlier with rej_cnt < `MAX_REJ` is dropped: rej_cnt++. There is no window update and no `level_valid`, but the compute cycle still occurs.
  - An outlier with rej_cnt = `MAX_REJ` is accepted and rej_cnt clears.
  - An in-range sample clears rej_cnt.
- Compute cycle:
  - If the sample entered the window and the state is (now) RUN, update `level`, pulse `level_valid`.
  - Pulse `level_changed` iff the new level ≠ the old level.
- Reset values:
  - `level`=0, `level_valid`=0, `level_changed`=0, `raw_ready`=1.
  - Window, sum, avg, count and rej_cnt = 0; state FILL; busy=0.
- Reset mid-operation, including during a compute cycle: everything returns to reset values immediately (asynchronous). The in-flight sample is lost, and warm-up restarts.

## Timing
- Sample accepted at edge N: the window and sum update at edge N. At edge N+1, `level`, avg and strobes are registered.
- `level_valid` and `level_changed` are high for exactly the cycle after edge N+1 and deassert at N+2.
- `raw_ready` is low from edge N to edge N+1. Maximum throughput is one sample per 2 cycles.
- `raw_valid` held high continuously: `raw_ready` alternates 1,0,1,0 starting at 1.
- First `level_valid` after reset follows acceptance of the `DEPTH`-th sample.
- `level` is stable in every cycle between `level_valid` pulses, so the downstream FSM may sample it on any edge.

## Structure
- Package `temp_pkg` holds:
  - the state enum {FILL, RUN}
  - the constants `TEMP_RAW_W`=8 and `TEMP_LVL_W`=5, shared with the mode FSM
- Sub-module `sample_window` holds the shift register, running sum and fill count. Its ports are push, data in, sum out and full.
- Top level holds the spike check, reject counter, handshake and output registers.

## Test plan
- Warm-up: after reset feed 80,80,80,80 → no `level_valid` for samples 1–3. After sample 4: `level`=10, `level_valid`=1 for one cycle, `level_changed`=1.
- Back-pressure: `raw_valid` held high with incrementing data → `raw_ready` toggles 1,0,…; exactly one acceptance per 2 cycles, and no sample is accepted twice.
- Spike: window at 80, feed 200,200 → both dropped, no `level_valid`. Third 200 → forced in: sum=440, avg=110, `level`=13, `level_changed`=1.
- No change: window at 80, feed 81 → avg=80, `level`=10, `level_valid`=1, `level_changed`=0. A following 144 (diff=64, not >64) → accepted.
- Full scale: fill with 255×4 → sum=1020, `level`=31, no overflow.
- Reset mid-run: assert `rst` during a compute cycle → `level`=0 and strobes=0 in the same cycle. The next 3 samples produce no `level_valid`; the 4th does.

Source files
------------

// File: rtl/temp_pkg.sv
// ---------------------------------------------------------------------------
// temp_pkg
// Shared definitions for the temperature conditioning path and the downstream
// hysteresis mode FSM.
//   TEMP_RAW_W   : raw sensor sample width
//   TEMP_LVL_W   : conditioned level width (mode FSM input width)
//   temp_state_e : filter warm-up / run state
// ---------------------------------------------------------------------------
package temp_pkg;

    localparam int TEMP_RAW_W = 8;
    localparam int TEMP_LVL_W = 5;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } temp_state_e;

endpackage

// File: rtl/temp_sample_filter_if.sv
// ---------------------------------------------------------------------------
// temp_sample_filter_if
// Sensor-side valid/ready handshake plus the held level output and strobes.
//   raw, raw_valid  : sample and its qualifier (sensor -> filter)
//   raw_ready       : filter can take a sample this cycle (filter -> sensor)
//   level           : filtered level, held between updates
//   level_valid     : one-cycle pulse when level is updated
//   level_changed   : one-cycle pulse with level_valid when level moved
// Modports: master = sensor/consumer side, slave = filter.
// ---------------------------------------------------------------------------
interface temp_sample_filter_if
    import temp_pkg::*;
#(
    parameter int DATA_W = TEMP_RAW_W,
    parameter int OUT_W  = TEMP_LVL_W
) ();

    logic [DATA_W-1:0] raw;
    logic              raw_valid;
    logic              raw_ready;
    logic [OUT_W-1:0]  level;
    logic              level_valid;
    logic              level_changed;

    modport master (
        output raw, raw_valid,
        input  raw_ready, level, level_valid, level_changed
    );

    modport slave (
        input  raw, raw_valid,
        output raw_ready, level, level_valid, level_changed
    );

endinterface

// File: rtl/sample_window.sv
// ---------------------------------------------------------------------------
// sample_window
// Moving-average window: DEPTH-deep shift register of samples, running sum
// and fill count.
//   clk, rst : clock, asynchronous active-high reset
//   push     : shift din into the window this cycle
//   din      : sample to enter
//   sum      : running sum of the DEPTH most recent samples
//   full     : DEPTH samples have entered since reset
// ---------------------------------------------------------------------------
module sample_window
    import temp_pkg::*;
#(
    parameter int DATA_W = TEMP_RAW_W,
    parameter int DEPTH  = 4,
    parameter int SUM_W  = DATA_W + $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    output logic [SUM_W-1:0]  sum,
    output logic              full
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] taps [DEPTH];
    logic [CNT_W-1:0]  count;

    // Taps clear on reset, so the oldest tap reads 0 throughout warm-up and
    // the running sum needs no special case while filling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
            sum   <= '0;
            count <= '0;
        end else if (push) begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
            sum <= sum + SUM_W'(din) - SUM_W'(taps[DEPTH-1]);
            if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
        end
    end

    assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/temp_sample_filter.sv
// ---------------------------------------------------------------------------
// temp_sample_filter
// Turns raw temperature samples into the level driving the hysteresis mode
// FSM: DEPTH-sample moving average with spike rejection, warm-up suppression
// and a held output with update/change strobes.
//   clk, rst : clock, asynchronous active-high reset
//   sif      : slave side of temp_sample_filter_if (raw handshake in,
//              level / level_valid / level_changed out)
// Each accepted sample costs one extra compute cycle with raw_ready low.
// ---------------------------------------------------------------------------
module temp_sample_filter
    import temp_pkg::*;
#(
    parameter int DATA_W   = TEMP_RAW_W,
    parameter int OUT_W    = TEMP_LVL_W,
    parameter int DEPTH    = 4,
    parameter int SPIKE_TH = 64,
    parameter int MAX_REJ  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    temp_sample_filter_if.slave  sif
);

    localparam int LOG_D = $clog2(DEPTH);
    localparam int SUM_W = DATA_W + LOG_D;
    localparam int REJ_W = $clog2(MAX_REJ + 1);

    // |a - b| evaluated as a signed (DATA_W+1)-bit difference
    function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d < 0) d = -d;
        return $unsigned(d);
    endfunction

    function automatic logic [DATA_W-1:0] sum_to_avg(input logic [SUM_W-1:0] s);
        return s[SUM_W-1:LOG_D];
    endfunction

    // Truncating requantisation, no rounding
    function automatic logic [OUT_W-1:0] to_level(input logic [DATA_W-1:0] a);
        return a[DATA_W-1 -: OUT_W];
    endfunction

    temp_state_e       state_q, state_d;
    logic              busy_q, busy_d;
    logic [REJ_W-1:0]  rej_cnt;
    logic              accept, outlier, drop, push;
    logic [SUM_W-1:0]  win_sum;
    logic              win_full;
    logic [DATA_W-1:0] new_avg;

    logic              push_p1;
    logic [DATA_W-1:0] avg_p1;
    logic [OUT_W-1:0]  level_p1;
    logic              vld_p1, chg_p1;

    // ---- stage p0: handshake, spike check, window entry ----
    assign accept  = sif.raw_valid && sif.raw_ready;
    assign outlier = (state_q == RUN) &&
                     (abs_diff(sif.raw, avg_p1) > (DATA_W+1)'(SPIKE_TH));
    assign drop    = outlier && (rej_cnt < REJ_W'(MAX_REJ));
    assign push    = accept && !drop;

    sample_window #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .SUM_W  (SUM_W)
    ) u_window (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (sif.raw),
        .sum  (win_sum),
        .full (win_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            busy_q  <= 1'b0;
            rej_cnt <= '0;
            push_p1 <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            push_p1 <= push;
            if (accept && state_q == RUN)
                rej_cnt <= drop ? rej_cnt + 1'b1 : '0;
        end
    end

    // Busy for exactly the cycle after an acceptance; FILL leaves once the
    // window reports full, which happens at the DEPTH-th entry.
    always_comb begin
        state_d = state_q;
        busy_d  = accept;
        case (state_q)
            FILL:    if (win_full) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = FILL;
        endcase
    end

    // ---- stage p1: average, level and strobes ----
    assign new_avg = sum_to_avg(win_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_p1   <= '0;
            level_p1 <= '0;
            vld_p1   <= 1'b0;
            chg_p1   <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            chg_p1 <= 1'b0;
            if (push_p1) begin
                avg_p1 <= new_avg;
                if (win_full) begin
                    level_p1 <= to_level(new_avg);
                    vld_p1   <= 1'b1;
                    chg_p1   <= (to_level(new_avg) != level_p1);
                end
            end
        end
    end

    assign sif.raw_ready     = !busy_q;
    assign sif.level         = level_p1;
    assign sif.level_valid   = vld_p1;
    assign sif.level_changed = chg_p1;

endmodule

// File: tb/tb_temp_sample_filter.sv
// ---------------------------------------------------------------------------
// tb_temp_sample_filter
// Scoreboard bench: stimulus pushes hand-computed expected level updates
// (level, changed flag, cycle of appearance) into a queue; a forked monitor
// pops and compares whenever level_valid is seen.
// ---------------------------------------------------------------------------
module tb_temp_sample_filter;
    import temp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    temp_sample_filter_if #(.DATA_W(TEMP_RAW_W), .OUT_W(TEMP_LVL_W)) bus ();

    temp_sample_filter #(
        .DATA_W(TEMP_RAW_W), .OUT_W(TEMP_LVL_W), .DEPTH(4),
        .SPIKE_TH(64), .MAX_REJ(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (bus.slave)
    );

    typedef struct {
        logic [4:0] lvl;
        logic       chg;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.level_changed && !bus.level_valid)
                    check("changed_without_valid", 1, 0);
                if (bus.level_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_level_valid", bus.level, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        check("level", bus.level, e.lvl);
                        check("level_changed", bus.level_changed, e.chg);
                        check("latency_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.raw_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one sample; push an expectation if it must produce a level update
    task automatic send(input logic [7:0] d, input bit ev, input logic [4:0] el, input bit ec);
        int n = 0;
        @(negedge clk);
        bus.raw = d;
        bus.raw_valid = 1'b1;
        while (!bus.raw_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.raw_ready) begin
            check("send_ready_timeout", 0, 1);
            bus.raw_valid = 1'b0;
        end else begin
            if (ev) q.push_back('{lvl: el, chg: ec, cyc: cyc + 2});
            @(posedge clk);
            #1 bus.raw_valid = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        repeat (5) @(negedge clk);
        check(nm, q.size(), 0);
        q.delete();
    endtask

    logic [4:0] bp_lvl [7] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd2};
    bit         bp_chg [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int acc_n;
        bus.raw = '0;
        bus.raw_valid = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        do_reset();
        @(negedge clk);
        check("reset_level", bus.level, 0);
        check("reset_level_valid", bus.level_valid, 0);
        check("reset_level_changed", bus.level_changed, 0);
        check("reset_raw_ready", bus.raw_ready, 1);

        // Warm-up: 80 x4, only the 4th produces an update
        send(8'd80, 0, 0, 0);
        send(8'd80, 0, 0, 0);
        send(8'd80, 0, 0, 0);
        send(8'd80, 1, 5'd10, 1);
        drain("warmup_drain");

        // No change then boundary diff of exactly 64
        send(8'd81, 1, 5'd10, 0);   // sum 321, avg 80
        send(8'd144, 1, 5'd12, 1);  // sum 385, avg 96
        drain("nochange_drain");

        // Spikes: two drops, third forced in, reject count clears on in-range
        do_reset();
        send(8'd80, 0, 0, 0);
        send(8'd80, 0, 0, 0);
        send(8'd80, 0, 0, 0);
        send(8'd80, 1, 5'd10, 1);
        send(8'd200, 0, 0, 0);
        send(8'd200, 0, 0, 0);
        send(8'd200, 1, 5'd13, 1);  // sum 440, avg 110
        send(8'd80, 1, 5'd13, 0);   // sum 440
        send(8'd200, 0, 0, 0);      // diff 90: dropped
        send(8'd80, 1, 5'd13, 0);   // in range, clears reject count
        send(8'd250, 0, 0, 0);
        send(8'd250, 0, 0, 0);
        send(8'd250, 1, 5'd19, 1);  // sum 610, avg 152
        drain("spike_drain");

        // Back-pressure: raw_valid held high, data advances only on acceptance
        do_reset();
        acc_n = 0;
        @(negedge clk);
        bus.raw = 8'd10;
        bus.raw_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_raw_ready", bus.raw_ready, (i % 2 == 0));
            if (bus.raw_ready) begin
                if (acc_n >= 3 && acc_n < 10)
                    q.push_back('{lvl: bp_lvl[acc_n-3], chg: bp_chg[acc_n-3], cyc: cyc + 2});
                acc_n++;
                @(posedge clk);
                #1 bus.raw = bus.raw + 8'd1;
            end
        end
        bus.raw_valid = 1'b0;
        check("bp_accept_count", acc_n, 10);
        drain("bp_drain");

        // Full scale: no overflow
        do_reset();
        send(8'd255, 0, 0, 0);
        send(8'd255, 0, 0, 0);
        send(8'd255, 0, 0, 0);
        send(8'd255, 1, 5'd31, 1);
        send(8'd255, 1, 5'd31, 0);
        drain("fullscale_drain");

        // Reset during a compute cycle
        send(8'd255, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("midrst_level", bus.level, 0);
        check("midrst_level_valid", bus.level_valid, 0);
        check("midrst_level_changed", bus.level_changed, 0);
        check("midrst_raw_ready", bus.raw_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(8'd100, 0, 0, 0);
        send(8'd100, 0, 0, 0);
        send(8'd100, 0, 0, 0);
        send(8'd100, 1, 5'd12, 1);  // sum 400, avg 100
        drain("midrst_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
